// File: rtl/vga_box_renderer.sv
// ----------------------------------------------------------------------------
// vga_box_renderer
//   Pixel-generation stage that sits directly after vga_sync. It paints a
//   background, a one-pixel frame border and a solid square box that moves
//   diagonally and bounces off the edges of the visible area. The box is
//   moved by a small FSM that runs once per frame during vertical blanking,
//   so the picture never tears.
//
// Ports
//   clk        in   1   pixel clock (same clock as vga_sync)
//   rst        in   1   synchronous, active-high reset
//   pixel_x    in   11  current column from vga_sync
//   pixel_y    in   11  current row from vga_sync
//   videoon    in   1   1 = visible region
//   h_synq     in   1   horizontal sync from vga_sync
//   v_synq     in   1   vertical sync from vga_sync
//   move_en    in   1   1 = box moves on each frame tick
//   rgb        out  12  {R[3:0],G[3:0],B[3:0]}, registered
//   h_sync_o   out  1   h_synq delayed by one cycle
//   v_sync_o   out  1   v_synq delayed by one cycle
//   bounce     out  1   one-cycle pulse when any wall is hit
//   corner_hit out  1   one-cycle pulse when both walls are hit in one frame
// ----------------------------------------------------------------------------
module vga_box_renderer #(
   parameter int unsigned H_ACTIVE  = 640,
   parameter int unsigned V_ACTIVE  = 480,
   parameter int unsigned BOX_SIZE  = 32,
   parameter int unsigned STEP      = 4,
   parameter int unsigned INIT_X    = 100,
   parameter int unsigned INIT_Y    = 100,
   parameter logic [11:0] BG_COLOR  = 12'h111,
   parameter logic [11:0] BRD_COLOR = 12'hFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [10:0] pixel_x,
   input  logic [10:0] pixel_y,
   input  logic        videoon,
   input  logic        h_synq,
   input  logic        v_synq,
   input  logic        move_en,
   output logic [11:0] rgb,
   output logic        h_sync_o,
   output logic        v_sync_o,
   output logic        bounce,
   output logic        corner_hit
);

   // 12-bit constants: every position sum is formed one bit wider than the
   // 11-bit coordinates so that box edge + step cannot wrap.
   localparam logic [11:0] H_LIM  = 12'(H_ACTIVE);
   localparam logic [11:0] V_LIM  = 12'(V_ACTIVE);
   localparam logic [11:0] BOX12  = 12'(BOX_SIZE);
   localparam logic [11:0] STEP12 = 12'(STEP);
   localparam logic [10:0] STEP11 = 11'(STEP);

   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_UPD_X = 2'd1,
      ST_UPD_Y = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Result of moving the box one step along a single axis.
   typedef struct packed {
      logic [10:0] pos;
      logic        dir;   // 1 = increasing coordinate (right / down)
      logic        hit;   // a wall was reached this frame
   } axis_t;

   function automatic logic [11:0] palette(input logic [1:0] idx);
      logic [11:0] c;
      case (idx)
         2'd0:    c = 12'hF00;
         2'd1:    c = 12'h0F0;
         2'd2:    c = 12'h00F;
         2'd3:    c = 12'hFF0;
         default: c = 12'h000;
      endcase
      return c;
   endfunction

   // One axis step. Moving forward, the box is clamped flush against the far
   // wall when the next step would overshoot; moving backward it is clamped to
   // 0. Either clamp reverses the direction and flags a hit.
   function automatic axis_t axis_step(input logic [10:0] pos,
                                       input logic        dir,
                                       input logic [11:0] limit);
      axis_t       r;
      logic [11:0] far_edge;
      far_edge = {1'b0, pos} + BOX12 + STEP12;
      r.pos    = pos;
      r.dir    = dir;
      r.hit    = 1'b0;
      if (dir) begin
         if (far_edge > limit) begin
            r.pos = 11'(limit - BOX12);
            r.dir = 1'b0;
            r.hit = 1'b1;
         end else begin
            r.pos = pos + STEP11;
         end
      end else begin
         if ({1'b0, pos} < STEP12) begin
            r.pos = 11'd0;
            r.dir = 1'b1;
            r.hit = 1'b1;
         end else begin
            r.pos = pos - STEP11;
         end
      end
      return r;
   endfunction

   state_t      state_q, state_d;
   logic [10:0] box_x_q, box_x_d;
   logic [10:0] box_y_q, box_y_d;
   logic        dx_q, dx_d;
   logic        dy_q, dy_d;
   logic        hx_q, hx_d;
   logic        hy_q, hy_d;
   logic [1:0]  color_idx_q, color_idx_d;
   logic [11:0] rgb_q, rgb_d;
   logic        h_sync_q, v_sync_q;
   logic        bounce_q, bounce_d;
   logic        corner_q, corner_d;

   logic        frame_tick_s;
   axis_t       ax_s, ay_s;
   logic        in_box_s, on_border_s;

   assign frame_tick_s = (pixel_y == 11'(V_ACTIVE)) && (pixel_x == 11'd0);

   // Candidate X/Y moves; only committed in the matching FSM state.
   always_comb begin
      ax_s = axis_step(box_x_q, dx_q, H_LIM);
      ay_s = axis_step(box_y_q, dy_q, V_LIM);
   end

   // Pixel classification and colour selection for the registered rgb.
   always_comb begin
      in_box_s    = ({1'b0, pixel_x} >= {1'b0, box_x_q}) &&
                    ({1'b0, pixel_x} <  ({1'b0, box_x_q} + BOX12)) &&
                    ({1'b0, pixel_y} >= {1'b0, box_y_q}) &&
                    ({1'b0, pixel_y} <  ({1'b0, box_y_q} + BOX12));
      on_border_s = (pixel_x == 11'd0) || (pixel_x == 11'(H_ACTIVE - 1)) ||
                    (pixel_y == 11'd0) || (pixel_y == 11'(V_ACTIVE - 1));
      rgb_d       = 12'h000;
      if (!videoon) begin
         rgb_d = 12'h000;
      end else if (in_box_s) begin
         rgb_d = palette(color_idx_q);
      end else if (on_border_s) begin
         rgb_d = BRD_COLOR;
      end else begin
         rgb_d = BG_COLOR;
      end
   end

   // Motion FSM: next state, box/direction updates and bounce reporting.
   always_comb begin
      state_d     = state_q;
      box_x_d     = box_x_q;
      box_y_d     = box_y_q;
      dx_d        = dx_q;
      dy_d        = dy_q;
      hx_d        = hx_q;
      hy_d        = hy_q;
      color_idx_d = color_idx_q;
      bounce_d    = 1'b0;
      corner_d    = 1'b0;
      case (state_q)
         ST_WAIT: begin
            if (frame_tick_s && move_en) begin
               state_d = ST_UPD_X;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_UPD_X: begin
            box_x_d = ax_s.pos;
            dx_d    = ax_s.dir;
            hx_d    = ax_s.hit;
            state_d = ST_UPD_Y;
         end
         ST_UPD_Y: begin
            box_y_d = ay_s.pos;
            dy_d    = ay_s.dir;
            hy_d    = ay_s.hit;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            // A corner counts as one bounce: the colour advances only once.
            if (hx_q || hy_q) begin
               bounce_d    = 1'b1;
               color_idx_d = color_idx_q + 2'd1;
            end else begin
               bounce_d    = 1'b0;
            end
            corner_d = hx_q && hy_q;
            state_d  = ST_WAIT;
         end
         default: begin
            state_d = ST_WAIT;
         end
      endcase
   end

   // State, box and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_WAIT;
         box_x_q     <= 11'(INIT_X);
         box_y_q     <= 11'(INIT_Y);
         dx_q        <= 1'b1;
         dy_q        <= 1'b1;
         hx_q        <= 1'b0;
         hy_q        <= 1'b0;
         color_idx_q <= 2'd0;
         rgb_q       <= 12'h000;
         h_sync_q    <= 1'b1;
         v_sync_q    <= 1'b1;
         bounce_q    <= 1'b0;
         corner_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         box_x_q     <= box_x_d;
         box_y_q     <= box_y_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         hx_q        <= hx_d;
         hy_q        <= hy_d;
         color_idx_q <= color_idx_d;
         rgb_q       <= rgb_d;
         h_sync_q    <= h_synq;
         v_sync_q    <= v_synq;
         bounce_q    <= bounce_d;
         corner_q    <= corner_d;
      end
   end

   assign rgb        = rgb_q;
   assign h_sync_o   = h_sync_q;
   assign v_sync_o   = v_sync_q;
   assign bounce     = bounce_q;
   assign corner_hit = corner_q;

endmodule

// File: tb/tb_vga_box_renderer.sv
// ----------------------------------------------------------------------------
// tb_vga_box_renderer
//   Directed bench for vga_box_renderer. A behavioural model tracks box
//   position, direction and colour per frame tick using plain arithmetic; a
//   compare process checks rgb and the delayed syncs every cycle, and the
//   stimulus adds hand-computed literal expectations at key points.
//   Instance dut uses default parameters; dut2 starts at (576,416).
// ----------------------------------------------------------------------------
module tb_vga_box_renderer;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rst2;
   logic [10:0] pixel_x, pixel_y;
   logic        videoon, h_synq, v_synq, move_en;
   logic [11:0] rgb, rgb2;
   logic        h_sync_o, v_sync_o, bounce, corner_hit;
   logic        h_sync_o2, v_sync_o2, bounce2, corner_hit2;

   vga_box_renderer dut (
      .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .videoon(videoon), .h_synq(h_synq), .v_synq(v_synq), .move_en(move_en),
      .rgb(rgb), .h_sync_o(h_sync_o), .v_sync_o(v_sync_o),
      .bounce(bounce), .corner_hit(corner_hit)
   );

   vga_box_renderer #(.INIT_X(576), .INIT_Y(416)) dut2 (
      .clk(clk), .rst(rst2), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .videoon(videoon), .h_synq(h_synq), .v_synq(v_synq), .move_en(move_en),
      .rgb(rgb2), .h_sync_o(h_sync_o2), .v_sync_o(v_sync_o2),
      .bounce(bounce2), .corner_hit(corner_hit2)
   );

   int checks = 0;
   int errors = 0;

   // Model state, index 0 = dut, 1 = dut2.
   int mx[2], my[2], mc[2];
   bit mdx[2], mdy[2];           // 1 = right / down
   int exp_b[2], exp_c[2];       // expected bounce / corner pulses after a tick
   int b_cnt[2], c_cnt[2];       // observed pulses since the tick

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   function automatic int pal(input int idx);
      case (idx % 4)
         0:       return 'hF00;
         1:       return 'h0F0;
         2:       return 'h00F;
         default: return 'hFF0;
      endcase
   endfunction

   function automatic void model_reset(input int i, input int ix, input int iy);
      mx[i] = ix; my[i] = iy; mdx[i] = 1'b1; mdy[i] = 1'b1; mc[i] = 0;
   endfunction

   // One frame of motion on a 640x480 field with a 32-pixel box, step 4.
   function automatic void model_tick(input int i);
      bit hx, hy;
      hx = 1'b0; hy = 1'b0;
      if (mdx[i]) begin
         if (mx[i] + 36 > 640) begin mx[i] = 608; mdx[i] = 1'b0; hx = 1'b1; end
         else mx[i] += 4;
      end else begin
         if (mx[i] < 4) begin mx[i] = 0; mdx[i] = 1'b1; hx = 1'b1; end
         else mx[i] -= 4;
      end
      if (mdy[i]) begin
         if (my[i] + 36 > 480) begin my[i] = 448; mdy[i] = 1'b0; hy = 1'b1; end
         else my[i] += 4;
      end else begin
         if (my[i] < 4) begin my[i] = 0; mdy[i] = 1'b1; hy = 1'b1; end
         else my[i] -= 4;
      end
      exp_b[i] = (hx || hy) ? 1 : 0;
      exp_c[i] = (hx && hy) ? 1 : 0;
      if (hx || hy) mc[i] = (mc[i] + 1) % 4;
   endfunction

   function automatic int exp_rgb(input int px, input int py, input bit vo);
      if (!vo) return 0;
      if (px >= mx[0] && px < mx[0] + 32 && py >= my[0] && py < my[0] + 32)
         return pal(mc[0]);
      if (px == 0 || px == 639 || py == 0 || py == 479) return 'hFFF;
      return 'h111;
   endfunction

   // Per-cycle compare of dut outputs; inputs are still the values sampled
   // at this edge because stimulus changes them 2 time units after the edge.
   always @(posedge clk) begin
      #1;
      if (rst) begin
         chk("rst_rgb", rgb, 0);
         chk("rst_hsync", h_sync_o, 1);
         chk("rst_vsync", v_sync_o, 1);
         chk("rst_bounce", bounce, 0);
         chk("rst_corner", corner_hit, 0);
      end else begin
         chk("rgb", rgb, exp_rgb(pixel_x, pixel_y, videoon));
         chk("hsync_dly", h_sync_o, h_synq);
         chk("vsync_dly", v_sync_o, v_synq);
      end
      if (bounce)      b_cnt[0]++;
      if (corner_hit)  c_cnt[0]++;
      if (bounce2)     b_cnt[1]++;
      if (corner_hit2) c_cnt[1]++;
   end

   task automatic step_in(input int px, input int py, input bit vo,
                          input bit hs, input bit vs);
      @(posedge clk);
      #2;
      pixel_x = 11'(px); pixel_y = 11'(py);
      videoon = vo; h_synq = hs; v_synq = vs;
   endtask

   task automatic settle_check(input int i);
      if (i == 0) begin
         chk("box_x", dut.box_x_q, mx[0]);
         chk("box_y", dut.box_y_q, my[0]);
         chk("dx", dut.dx_q, mdx[0]);
         chk("dy", dut.dy_q, mdy[0]);
         chk("color", dut.color_idx_q, mc[0]);
      end else begin
         chk("box2_x", dut2.box_x_q, mx[1]);
         chk("box2_y", dut2.box_y_q, my[1]);
         chk("color2", dut2.color_idx_q, mc[1]);
      end
      chk("bounce_cnt", b_cnt[i], exp_b[i]);
      chk("corner_cnt", c_cnt[i], exp_c[i]);
   endtask

   // One frame tick followed by enough blanking cycles for the FSM to finish.
   task automatic do_tick(input bit men);
      for (int i = 0; i < 2; i++) begin
         b_cnt[i] = 0; c_cnt[i] = 0; exp_b[i] = 0; exp_c[i] = 0;
      end
      @(posedge clk);
      #2;
      move_en = men;
      pixel_x = 11'd0; pixel_y = 11'd480; videoon = 1'b0;
      if (men) begin
         model_tick(0);
         if (!rst2) model_tick(1);
      end
      step_in(1, 480, 0, 1, 1);
      repeat (6) @(posedge clk);
      #1;
      settle_check(0);
      if (!rst2) settle_check(1);
   endtask

   int save_x, save_y;

   initial begin
      rst = 1'b1; rst2 = 1'b1; move_en = 1'b0;
      pixel_x = 11'd0; pixel_y = 11'd0; videoon = 1'b0;
      h_synq = 1'b1; v_synq = 1'b1;
      for (int i = 0; i < 2; i++) begin
         b_cnt[i] = 0; c_cnt[i] = 0; exp_b[i] = 0; exp_c[i] = 0;
      end
      model_reset(0, 100, 100);
      model_reset(1, 576, 416);

      // 1. reset
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rgb", rgb, 'h000);
      chk("reset_hsync", h_sync_o, 1);
      chk("reset_box_x", dut.box_x_q, 100);
      chk("reset_box_y", dut.box_y_q, 100);
      chk("reset_bounce", bounce, 0);
      #1 rst = 1'b0;

      // 2. pixel colours
      step_in(100, 100, 1, 1, 1); @(posedge clk); #1 chk("box_top_left", rgb, 'hF00);
      step_in(99, 100, 1, 1, 1);  @(posedge clk); #1 chk("left_of_box", rgb, 'h111);
      step_in(0, 5, 1, 1, 1);     @(posedge clk); #1 chk("border_left", rgb, 'hFFF);
      step_in(131, 131, 1, 1, 1); @(posedge clk); #1 chk("box_bot_right", rgb, 'hF00);
      step_in(132, 100, 1, 1, 1); @(posedge clk); #1 chk("right_of_box", rgb, 'h111);
      step_in(100, 132, 1, 1, 1); @(posedge clk); #1 chk("below_box", rgb, 'h111);
      step_in(639, 200, 1, 1, 1); @(posedge clk); #1 chk("border_right", rgb, 'hFFF);
      step_in(300, 479, 1, 1, 1); @(posedge clk); #1 chk("border_bottom", rgb, 'hFFF);

      // 3. blanking inside box, sync delay
      step_in(110, 110, 0, 1, 1); @(posedge clk); #1 chk("blank_in_box", rgb, 'h000);
      step_in(110, 110, 0, 0, 1);
      #1 chk("hsync_not_yet", h_sync_o, 1);
      @(posedge clk); #1 chk("hsync_follows", h_sync_o, 0);
      step_in(110, 110, 0, 1, 0); @(posedge clk); #1 chk("vsync_follows", v_sync_o, 0);
      step_in(200, 200, 1, 1, 1);

      // 4. 129 ticks with default parameters
      for (int t = 1; t <= 129; t++) begin
         do_tick(1'b1);
         if (t == 88)  chk("y_bottom_t88", dut.box_y_q, 448);
         if (t == 127) chk("x_t127", dut.box_x_q, 608);
         if (t == 128) begin
            chk("x_t128", dut.box_x_q, 608);
            chk("dx_t128", dut.dx_q, 0);
            chk("bounce_t128", b_cnt[0], 1);
         end
         if (t == 129) chk("x_t129", dut.box_x_q, 604);
      end
      chk("color_t129", dut.color_idx_q, 2);
      // render check at the new position and colour
      step_in(604, 284, 1, 1, 1); @(posedge clk); #1 chk("moved_box_px", rgb, 'h00F);
      step_in(603, 284, 1, 1, 1);

      // 5. corner from (576,416)
      @(posedge clk); #2 rst2 = 1'b0;
      for (int t = 1; t <= 9; t++) do_tick(1'b1);
      chk("corner_x", dut2.box_x_q, 608);
      chk("corner_y", dut2.box_y_q, 448);
      chk("corner_dx", dut2.dx_q, 0);
      chk("corner_dy", dut2.dy_q, 0);
      chk("corner_bounce", b_cnt[1], 1);
      chk("corner_pulse", c_cnt[1], 1);
      chk("corner_color", dut2.color_idx_q, 1);

      // 6. frozen motion, then reset while the FSM is busy
      save_x = mx[0]; save_y = my[0];
      for (int t = 1; t <= 3; t++) do_tick(1'b0);
      chk("frozen_x", dut.box_x_q, save_x);
      chk("frozen_y", dut.box_y_q, save_y);
      move_en = 1'b1;
      @(posedge clk);
      #2;
      pixel_x = 11'd0; pixel_y = 11'd480; videoon = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1; pixel_x = 11'd1;
      model_reset(0, 100, 100);
      @(posedge clk);
      #2 rst = 1'b0;
      b_cnt[0] = 0;
      repeat (6) @(posedge clk);
      #1;
      chk("rst_mid_x", dut.box_x_q, 100);
      chk("rst_mid_y", dut.box_y_q, 100);
      chk("rst_mid_color", dut.color_idx_q, 0);
      chk("rst_mid_state", int'(dut.state_q), 0);
      chk("rst_mid_bounce", b_cnt[0], 0);
      step_in(100, 100, 1, 1, 1); @(posedge clk); #1 chk("after_rst_px", rgb, 'hF00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
